// File: rtl/arb_ram_pkg.sv
// arb_ram_pkg: shared types and constants for the arbitrated single-port RAM
package arb_ram_pkg;
  typedef enum logic {CLEAR, IDLE} state_t;
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;
  localparam int PRIORITY_FIXED = 0;
  localparam int PRIORITY_RR = 1;
endpackage

// File: rtl/arb_ram_array.sv
// arb_ram_array: synchronous single-port array written for block-RAM inference
module arb_ram_array #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/arb_ram.sv
// arb_ram: two requesters sharing one single-port RAM with fixed or round-robin arbitration.
// Define ARB_RAM_CLEAR_EN to zero the array after every reset (busy while clearing).
module arb_ram
  import arb_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 8,
  parameter int PRIORITY_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  a_ack,
  output logic                  b_ack,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  a_rvalid,
  output logic                  b_rvalid,
  output logic                  busy
);
  logic                  clr;
  logic                  last_grant;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata, mem_rdata, a_hold, b_hold;
`ifdef ARB_RAM_CLEAR_EN
  state_t state;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt <= '0;
    end else if (state == CLEAR) begin
      cnt <= cnt + 1'b1;
      if (&cnt) state <= IDLE;
    end
  end
  assign clr = state == CLEAR;
`else
  assign cnt = '0;
  assign clr = 1'b0;
`endif
  assign busy = clr;
  // A wins unless B contends under round-robin and A was granted last
  assign a_ack = rst_n && !clr && a_req &&
                 (!b_req || PRIORITY_MODE == PRIORITY_FIXED || last_grant == PORT_B);
  assign b_ack = rst_n && !clr && b_req && !a_ack;
  assign mem_we    = clr || (a_ack ? a_we : (b_ack && b_we));
  assign mem_addr  = clr ? cnt : a_ack ? a_addr : b_addr;
  assign mem_wdata = clr ? '0 : a_ack ? a_wdata : b_wdata;
  arb_ram_array #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_hold <= '0;
      b_hold <= '0;
      last_grant <= PORT_B;
    end else begin
      a_rvalid <= a_ack && !a_we;
      b_rvalid <= b_ack && !b_we;
      if (a_rvalid) a_hold <= mem_rdata;
      if (b_rvalid) b_hold <= mem_rdata;
      if (a_ack) last_grant <= PORT_A;
      else if (b_ack) last_grant <= PORT_B;
    end
  end
  // The shared array output is only meaningful in the rvalid cycle; otherwise hold the last read
  assign a_rdata = a_rvalid ? mem_rdata : a_hold;
  assign b_rdata = b_rvalid ? mem_rdata : b_hold;
endmodule
